// File: rtl/s2_pipe_pkg.sv
// Shared types and sizing constants for the s2 sub-pipe RAM FIFO.
package s2_pipe_pkg;

  localparam int S2_RAM_DEPTH = 16;
  localparam int S2_PF_DEPTH  = 3;
  localparam int S2_RD_LAT    = 1;

  typedef logic [63:0] s2_word_t;
  typedef logic [3:0]  s2_addr_t;

  function automatic logic [1:0] pf_idx_inc(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/s2_prefetch_buf.sv
// Three-entry register FIFO that holds words already read out of the RAM,
// so the head word is always available combinationally downstream.
module s2_prefetch_buf
  import s2_pipe_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem_q [S2_PF_DEPTH];
  logic [DATA_W-1:0] mem_d [S2_PF_DEPTH];
  logic [1:0]        wr_idx_q, wr_idx_d;
  logic [1:0]        rd_idx_q, rd_idx_d;
  logic [1:0]        count_q, count_d;
  logic              pop_ok, push_ok;

  // Next-state for storage, indices and occupancy.
  always_comb begin
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && ((count_q != 2'd3) || pop_ok);
    mem_d    = mem_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    if (flush) begin
      wr_idx_d = 2'd0;
      rd_idx_d = 2'd0;
      count_d  = 2'd0;
    end else begin
      if (push_ok) begin
        mem_d[wr_idx_q] = push_data;
        wr_idx_d        = pf_idx_inc(wr_idx_q);
      end else begin
        wr_idx_d = wr_idx_q;
      end
      if (pop_ok) begin
        rd_idx_d = pf_idx_inc(rd_idx_q);
      end else begin
        rd_idx_d = rd_idx_q;
      end
      count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

  // State registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < S2_PF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_idx_q <= 2'd0;
      rd_idx_q <= 2'd0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_idx_q];
  assign count     = count_q;

endmodule

// File: rtl/s2_ram_fifo_ctrl.sv
// Stream-to-RAM FIFO controller owning the s2 16x64 dual-port RAM.
// Define S2_FIFO_STATS_EN to add the hwm / ovf_err statistics outputs.
module s2_ram_fifo_ctrl
  import s2_pipe_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] ram_address_a,
  output logic              ram_wren_a,
  output logic              ram_rden_a,
  output logic [DATA_W-1:0] ram_data_b,
  output logic [ADDR_W-1:0] ram_address_b,
  output logic              ram_wren_b,
  output logic              ram_rden_b,
  input  logic [DATA_W-1:0] ram_q_b,
  output logic [ADDR_W:0]   level
`ifdef S2_FIFO_STATS_EN
  ,
  output logic [ADDR_W:0]   hwm,
  output logic              ovf_err
`endif
);

  localparam int RAM_DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = RAM_DEPTH[ADDR_W:0];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [1:0]        inflight_q, inflight_d;
  logic              in_ready_q, in_ready_d;
  logic [1:0]        pf_count;
  logic              wr_fire, rd_go, capture;

  // The prefetch budget counts reads still in the RAM pipe, so it can never overflow.
  always_comb begin
    wr_fire    = in_valid && in_ready_q && !flush;
    rd_go      = (level_q != '0) &&
                 (({1'b0, pf_count} + {1'b0, inflight_q}) < 3'(S2_PF_DEPTH));
    capture    = (inflight_q != 2'd0);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    inflight_d = inflight_q;
    in_ready_d = in_ready_q;
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      inflight_d = 2'd0;
      in_ready_d = 1'b1;
    end else begin
      if (wr_fire) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (rd_go) begin
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      level_d    = level_q + (ADDR_W+1)'(wr_fire) - (ADDR_W+1)'(rd_go);
      inflight_d = inflight_q + {1'b0, rd_go} - {1'b0, capture};
      in_ready_d = (level_d != FULL_LVL);
    end
  end

  // Pointer, level and handshake registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      inflight_q <= 2'd0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      inflight_q <= inflight_d;
      in_ready_q <= in_ready_d;
    end
  end

  s2_prefetch_buf #(
    .DATA_W (DATA_W)
  ) u_pf (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (capture),
    .push_data (ram_q_b),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .count     (pf_count)
  );

  assign in_ready      = in_ready_q;
  assign level         = level_q;
  assign ram_data_a    = in_data;
  assign ram_address_a = wr_ptr_q;
  assign ram_wren_a    = wr_fire;
  assign ram_rden_a    = 1'b0;
  assign ram_data_b    = '0;
  assign ram_address_b = rd_ptr_q;
  assign ram_wren_b    = 1'b0;
  assign ram_rden_b    = rd_go;

`ifdef S2_FIFO_STATS_EN
  logic [ADDR_W:0] hwm_q, hwm_d;
  logic [6:0]      stall_cnt_q, stall_cnt_d;
  logic            ovf_q, ovf_d;
  logic            stall;

  // ovf_err fires on the 65th consecutive stalled cycle and then sticks.
  always_comb begin
    stall       = in_valid && !in_ready_q;
    hwm_d       = hwm_q;
    stall_cnt_d = stall_cnt_q;
    ovf_d       = ovf_q;
    if (flush) begin
      hwm_d       = '0;
      stall_cnt_d = 7'd0;
      ovf_d       = 1'b0;
    end else begin
      hwm_d = (level_q > hwm_q) ? level_q : hwm_q;
      if (stall) begin
        stall_cnt_d = (stall_cnt_q == 7'h7f) ? stall_cnt_q : stall_cnt_q + 7'd1;
      end else begin
        stall_cnt_d = 7'd0;
      end
      ovf_d = ovf_q | (stall && (stall_cnt_q >= 7'd64));
    end
  end

  // Statistics registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hwm_q       <= '0;
      stall_cnt_q <= 7'd0;
      ovf_q       <= 1'b0;
    end else begin
      hwm_q       <= hwm_d;
      stall_cnt_q <= stall_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  assign hwm     = hwm_q;
  assign ovf_err = ovf_q;
`endif

endmodule
